// File: rtl/posit_align_prep_pkg.sv
// Shared posit arithmetic types: decoded operand, alignment result and scale floor.
// Used by the decoder, the alignment front-end and the normaliser.
package posit_arith_pkg;

   localparam int POSIT_WORD_SIZE = 32;
   localparam int POSIT_RS        = 5;
   localparam int POSIT_SCALE_W   = 9;

   localparam logic [POSIT_SCALE_W-1:0] SCALE_MIN = {1'b1, {(POSIT_SCALE_W-1){1'b0}}};

   typedef struct packed {
      logic                       sign;
      logic [POSIT_SCALE_W-1:0]   scale;
      logic [POSIT_WORD_SIZE-1:0] mant;
      logic                       zero;
      logic                       nar;
   } posit_op_t;

   typedef struct packed {
      logic                       big_sign;
      logic [POSIT_SCALE_W-1:0]   big_scale;
      logic [POSIT_WORD_SIZE-1:0] big_mant;
      logic [POSIT_WORD_SIZE-1:0] small_mant;
      logic [POSIT_RS-1:0]        shamt;
      logic                       eff_sub;
      logic                       swap;
      logic                       nar;
      logic                       zero;
      logic                       sticky;
   } align_out_t;

   // A zero sorts below every real operand: lowest scale, empty mantissa.
   function automatic posit_op_t op_sanitise(input logic                       sign,
                                             input logic [POSIT_SCALE_W-1:0]   scale,
                                             input logic [POSIT_WORD_SIZE-1:0] mant,
                                             input logic                       zero,
                                             input logic                       nar);
      posit_op_t op;
      op.sign  = sign;
      op.scale = zero ? SCALE_MIN : scale;
      op.mant  = zero ? '0 : mant;
      op.zero  = zero;
      op.nar   = nar;
      return op;
   endfunction

endpackage

// File: rtl/posit_align_prep_if.sv
// Operand-pair input and aligned-pair output bundle of the posit alignment front-end.
// slave = the aligner's view, master = the producer/consumer side.
interface posit_align_prep_if #(
   parameter int WORD_SIZE = 32,
   parameter int RS        = 5,
   parameter int SCALE_W   = 9
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic                 a_sign;
   logic                 b_sign;
   logic [SCALE_W-1:0]   a_scale;
   logic [SCALE_W-1:0]   b_scale;
   logic [WORD_SIZE-1:0] a_mant;
   logic [WORD_SIZE-1:0] b_mant;
   logic                 a_zero;
   logic                 b_zero;
   logic                 a_nar;
   logic                 b_nar;

   logic                 out_valid;
   logic                 out_ready;
   logic                 big_sign;
   logic [SCALE_W-1:0]   big_scale;
   logic [WORD_SIZE-1:0] big_mant;
   logic [WORD_SIZE-1:0] small_mant;
   logic [RS-1:0]        shamt;
   logic                 eff_sub;
   logic                 swap;
   logic                 out_nar;
   logic                 out_zero;
   logic                 sticky;

   modport slave (
      input  in_valid, a_sign, b_sign, a_scale, b_scale, a_mant, b_mant,
             a_zero, b_zero, a_nar, b_nar, out_ready,
      output in_ready, out_valid, big_sign, big_scale, big_mant, small_mant,
             shamt, eff_sub, swap, out_nar, out_zero, sticky
   );

   modport master (
      output in_valid, a_sign, b_sign, a_scale, b_scale, a_mant, b_mant,
             a_zero, b_zero, a_nar, b_nar, out_ready,
      input  in_ready, out_valid, big_sign, big_scale, big_mant, small_mant,
             shamt, eff_sub, swap, out_nar, out_zero, sticky
   );
endinterface

// File: rtl/posit_align_prep_sticky_or.sv
// Sticky bit for the alignment shift: OR of the mantissa bits the shifter will drop.
// full=1 means the whole mantissa is shifted out.
module posit_sticky_or #(
   parameter int WORD_SIZE = 32,
   parameter int RS        = 5
) (
   input  logic [WORD_SIZE-1:0] mant,
   input  logic [RS-1:0]        shamt,
   input  logic                 full,
   output logic                 sticky
);
   logic [WORD_SIZE-1:0] mask;

   always_comb begin
      mask   = (WORD_SIZE'(1) << shamt) - WORD_SIZE'(1);
      sticky = full ? (|mant) : (|(mant & mask));
   end
endmodule

// File: rtl/posit_align_prep.sv
// Posit adder alignment front-end: orders two decoded operands by magnitude and
// produces the shift amount for the right shifter. Optional sticky via POSIT_ALIGN_STICKY_EN.
module posit_align_prep
   import posit_arith_pkg::*;
#(
   parameter int WORD_SIZE = POSIT_WORD_SIZE,
   parameter int RS        = POSIT_RS,
   parameter int SCALE_W   = POSIT_SCALE_W
) (
   input logic              clk,
   input logic              rst,
   posit_align_prep_if.slave io
);

   logic               s2_en;
   logic               s1_en;
   logic               in_fire;

   logic               s1_valid_q, s1_valid_d;
   posit_op_t          s1_a_q, s1_a_d;
   posit_op_t          s1_b_q, s1_b_d;
   logic [SCALE_W:0]   s1_diff_q, s1_diff_d;
   logic               s1_a_big_q, s1_a_big_d;

   logic               s2_valid_q, s2_valid_d;
   align_out_t         s2_out_q, s2_out_d;

   posit_op_t          a_in, b_in;
   logic [SCALE_W:0]   diff_in;

   posit_op_t          big_op, small_op;
   logic [SCALE_W:0]   absd;
   logic               far;
   logic               sticky_raw;
   align_out_t         res;

   always_comb begin
      s2_en   = !s2_valid_q || io.out_ready;
      s1_en   = !s1_valid_q || s2_en;
      in_fire = io.in_valid && s1_en && !rst;
   end

   assign io.in_ready = s1_en && !rst;

   // Stage 1: sanitise, subtract scales one bit wider so the difference cannot wrap.
   always_comb begin
      a_in    = op_sanitise(io.a_sign, io.a_scale, io.a_mant, io.a_zero, io.a_nar);
      b_in    = op_sanitise(io.b_sign, io.b_scale, io.b_mant, io.b_zero, io.b_nar);
      diff_in = {a_in.scale[SCALE_W-1], a_in.scale} - {b_in.scale[SCALE_W-1], b_in.scale};

      s1_valid_d = s1_en ? in_fire : s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_diff_d  = s1_diff_q;
      s1_a_big_d = s1_a_big_q;
      if (in_fire) begin
         s1_a_d     = a_in;
         s1_b_d     = b_in;
         s1_diff_d  = diff_in;
         s1_a_big_d = (diff_in != '0 && !diff_in[SCALE_W]) ||
                      (diff_in == '0 && a_in.mant >= b_in.mant);
      end
   end

   always_comb begin
      big_op   = s1_a_big_q ? s1_a_q : s1_b_q;
      small_op = s1_a_big_q ? s1_b_q : s1_a_q;
      absd     = s1_diff_q[SCALE_W] ? ('0 - s1_diff_q) : s1_diff_q;
      far      = absd >= (SCALE_W+1)'(WORD_SIZE);
   end

`ifdef POSIT_ALIGN_STICKY_EN
   posit_sticky_or #(
      .WORD_SIZE (WORD_SIZE),
      .RS        (RS)
   ) u_sticky_or (
      .mant   (small_op.mant),
      .shamt  (absd[RS-1:0]),
      .full   (far),
      .sticky (sticky_raw)
   );
`else
   assign sticky_raw = 1'b0;
`endif

   // Stage 2: select, clamp the shift, then let specials override.
   always_comb begin
      res.big_sign   = big_op.sign;
      res.big_scale  = big_op.scale;
      res.big_mant   = big_op.mant;
      res.small_mant = far ? '0 : small_op.mant;
      res.shamt      = far ? '0 : absd[RS-1:0];
      res.eff_sub    = big_op.sign != small_op.sign;
      res.swap       = !s1_a_big_q;
      res.nar        = s1_a_q.nar || s1_b_q.nar;
      res.zero       = s1_a_q.zero && s1_b_q.zero && !res.nar;
      res.sticky     = sticky_raw;
      if (res.nar) begin
         res.big_mant   = '0;
         res.small_mant = '0;
         res.shamt      = '0;
         res.sticky     = 1'b0;
      end else if (res.zero) begin
         res.big_sign = s1_a_q.sign && s1_b_q.sign;
      end

      s2_valid_d = s2_valid_q;
      s2_out_d   = s2_out_q;
      if (s2_en) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) s2_out_d = res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_diff_q  <= '0;
         s1_a_big_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_out_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_diff_q  <= s1_diff_d;
         s1_a_big_q <= s1_a_big_d;
         s2_valid_q <= s2_valid_d;
         s2_out_q   <= s2_out_d;
      end
   end

   assign io.out_valid  = s2_valid_q;
   assign io.big_sign   = s2_out_q.big_sign;
   assign io.big_scale  = s2_out_q.big_scale;
   assign io.big_mant   = s2_out_q.big_mant;
   assign io.small_mant = s2_out_q.small_mant;
   assign io.shamt      = s2_out_q.shamt;
   assign io.eff_sub    = s2_out_q.eff_sub;
   assign io.swap       = s2_out_q.swap;
   assign io.out_nar    = s2_out_q.nar;
   assign io.out_zero   = s2_out_q.zero;
   assign io.sticky     = s2_out_q.sticky;

endmodule

// File: tb/tb_posit_align_prep.sv
// Scoreboard bench for posit_align_prep: directed pairs with hand-computed alignments.
module tb_posit_align_prep;
   import posit_arith_pkg::*;

`ifdef POSIT_ALIGN_STICKY_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   typedef struct {
      align_out_t exp;
      align_out_t care;
      int         id;
   } sb_t;

   sb_t  sb_q[$];
   int   checks = 0;
   int   passes = 0;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   posit_align_prep_if #(.WORD_SIZE(32), .RS(5), .SCALE_W(9)) io ();

   posit_align_prep #(.WORD_SIZE(32), .RS(5), .SCALE_W(9)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io.slave)
   );

   function automatic posit_op_t op(input logic s, input int sc, input logic [31:0] m,
                                    input logic z, input logic n);
      posit_op_t o;
      o.sign = s; o.scale = 9'(sc); o.mant = m; o.zero = z; o.nar = n;
      return o;
   endfunction

   function automatic align_out_t mk(input logic s, input int sc, input logic [31:0] bm,
                                     input logic [31:0] sm, input int sh, input logic eff,
                                     input logic sw, input logic nar, input logic zr,
                                     input logic st);
      align_out_t r;
      r.big_sign = s; r.big_scale = 9'(sc); r.big_mant = bm; r.small_mant = sm;
      r.shamt = 5'(sh); r.eff_sub = eff; r.swap = sw; r.nar = nar; r.zero = zr;
      r.sticky = st & STK;
      return r;
   endfunction

   function automatic align_out_t grab();
      align_out_t r;
      r.big_sign = io.big_sign; r.big_scale = io.big_scale; r.big_mant = io.big_mant;
      r.small_mant = io.small_mant; r.shamt = io.shamt; r.eff_sub = io.eff_sub;
      r.swap = io.swap; r.nar = io.out_nar; r.zero = io.out_zero; r.sticky = io.sticky;
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s got=%0h want=%0h", name, got, want);
   endtask

   align_out_t care_all, care_nar, care_zero;

   initial begin
      care_all  = '1;
      care_nar  = '0;
      care_nar.nar = 1'b1; care_nar.zero = 1'b1; care_nar.big_mant = '1;
      care_nar.small_mant = '1; care_nar.shamt = '1; care_nar.sticky = 1'b1;
      care_zero = '0;
      care_zero.nar = 1'b1; care_zero.zero = 1'b1; care_zero.big_sign = 1'b1;
   end

   // Monitor: every presented output is checked against the queue head; popped on transfer.
   initial begin
      align_out_t act;
      forever begin
         @(negedge clk);
         if (!rst && io.out_valid) begin
            act = grab();
            checks++;
            if (sb_q.size() == 0) begin
               $display("FAIL unexpected_output got=%0h want=none", act);
            end else if (((act ^ sb_q[0].exp) & sb_q[0].care) == '0) begin
               passes++;
               if (io.out_ready) void'(sb_q.pop_front());
            end else begin
               $display("FAIL pair%0d got=%0h want=%0h care=%0h",
                        sb_q[0].id, act, sb_q[0].exp, sb_q[0].care);
               if (io.out_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic send(input posit_op_t a, input posit_op_t b, input align_out_t e,
                       input align_out_t c, input int id);
      bit   acc;
      sb_t  ent;
      io.in_valid = 1'b1;
      io.a_sign = a.sign; io.a_scale = a.scale; io.a_mant = a.mant;
      io.a_zero = a.zero; io.a_nar = a.nar;
      io.b_sign = b.sign; io.b_scale = b.scale; io.b_mant = b.mant;
      io.b_zero = b.zero; io.b_nar = b.nar;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         if (io.in_ready) begin
            acc = 1'b1;
            ent.exp = e; ent.care = c; ent.id = id;
            sb_q.push_back(ent);
         end
         @(posedge clk); #1;
      end
      if (!acc) begin
         checks++;
         $display("FAIL send_timeout pair%0d got=no_accept want=accept", id);
      end
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      chk(name, 128'(sb_q.size()), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bit saw_drop;
      rst = 1'b1;
      io.in_valid = 1'b0; io.out_ready = 1'b1;
      io.a_sign = 0; io.a_scale = '0; io.a_mant = '0; io.a_zero = 0; io.a_nar = 0;
      io.b_sign = 0; io.b_scale = '0; io.b_mant = '0; io.b_zero = 0; io.b_nar = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 128'(io.in_ready), 128'd0);
      chk("rst_out_valid", 128'(io.out_valid), 128'd0);
      chk("rst_outputs", 128'(grab()), 128'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 128'(io.in_ready), 128'd1);

      send(op(0,5,32'hC0000000,0,0), op(0,2,32'h80000000,0,0),
           mk(0,5,32'hC0000000,32'h80000000,3,0,0,0,0,0), care_all, 1);
      send(op(0,-4,32'h80000000,0,0), op(1,6,32'h90000000,0,0),
           mk(1,6,32'h90000000,32'h80000000,10,1,1,0,0,0), care_all, 2);
      send(op(0,3,32'h80000000,0,0), op(0,3,32'hA0000000,0,0),
           mk(0,3,32'hA0000000,32'h80000000,0,0,1,0,0,0), care_all, 3);
      send(op(0,3,32'hA0000000,0,0), op(0,3,32'hA0000000,0,0),
           mk(0,3,32'hA0000000,32'hA0000000,0,0,0,0,0,0), care_all, 4);
      send(op(0,40,32'hC0000000,0,0), op(0,0,32'h80000001,0,0),
           mk(0,40,32'hC0000000,32'h0,0,0,0,0,0,1), care_all, 5);
      send(op(0,4,32'h90000000,0,0), op(0,0,32'h8000000F,0,0),
           mk(0,4,32'h90000000,32'h8000000F,4,0,0,0,0,1), care_all, 6);
      send(op(0,31,32'h80000000,0,0), op(0,0,32'h80000000,0,0),
           mk(0,31,32'h80000000,32'h80000000,31,0,0,0,0,0), care_all, 7);
      send(op(0,32,32'h80000000,0,0), op(0,0,32'h80000000,0,0),
           mk(0,32,32'h80000000,32'h0,0,0,0,0,0,1), care_all, 8);
      send(op(0,7,32'h12345678,1,0), op(1,3,32'hC0000000,0,0),
           mk(1,3,32'hC0000000,32'h0,0,1,1,0,0,0), care_all, 9);
      send(op(0,1,32'h80000000,0,1), op(0,0,32'h80000000,0,0),
           mk(0,0,32'h0,32'h0,0,0,0,1,0,0), care_nar, 10);
      send(op(1,0,32'h0,1,0), op(0,0,32'h0,1,0),
           mk(0,0,32'h0,32'h0,0,0,0,0,1,0), care_zero, 11);
      send(op(1,0,32'h0,1,0), op(1,0,32'h0,1,0),
           mk(1,0,32'h0,32'h0,0,0,0,0,1,0), care_zero, 12);
      io.in_valid = 1'b0;
      drain("drain_directed");

      // Four back-to-back pairs with the consumer stalled for three cycles.
      saw_drop = 1'b0;
      fork
         begin
            send(op(0,5,32'hC0000000,0,0), op(0,2,32'h80000000,0,0),
                 mk(0,5,32'hC0000000,32'h80000000,3,0,0,0,0,0), care_all, 21);
            send(op(0,-4,32'h80000000,0,0), op(1,6,32'h90000000,0,0),
                 mk(1,6,32'h90000000,32'h80000000,10,1,1,0,0,0), care_all, 22);
            send(op(0,3,32'h80000000,0,0), op(0,3,32'hA0000000,0,0),
                 mk(0,3,32'hA0000000,32'h80000000,0,0,1,0,0,0), care_all, 23);
            send(op(0,3,32'hA0000000,0,0), op(0,3,32'hA0000000,0,0),
                 mk(0,3,32'hA0000000,32'hA0000000,0,0,0,0,0,0), care_all, 24);
            io.in_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 50 && !io.out_valid; k++) begin
               @(posedge clk); #1;
            end
            io.out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               if (!io.in_ready) saw_drop = 1'b1;
               @(posedge clk); #1;
            end
            io.out_ready = 1'b1;
         end
      join
      chk("stall_in_ready_drop", 128'(saw_drop), 128'd1);
      drain("drain_stall");

      // Reset while two pairs are in flight: neither may ever appear.
      io.out_ready = 1'b0;
      send(op(0,5,32'hC0000000,0,0), op(0,2,32'h80000000,0,0),
           mk(0,5,32'hC0000000,32'h80000000,3,0,0,0,0,0), care_all, 31);
      send(op(0,-4,32'h80000000,0,0), op(1,6,32'h90000000,0,0),
           mk(1,6,32'h90000000,32'h80000000,10,1,1,0,0,0), care_all, 32);
      io.in_valid = 1'b0;
      rst = 1'b1;
      sb_q.delete();
      @(posedge clk); #1;
      chk("midrst_out_valid", 128'(io.out_valid), 128'd0);
      chk("midrst_outputs", 128'(grab()), 128'd0);
      rst = 1'b0;
      io.out_ready = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("midrst_no_output", 128'(io.out_valid), 128'd0);
      chk("final_queue_empty", 128'(sb_q.size()), 128'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
